// File: rtl/conv_router_pkg.sv
// conv_router_pkg: shared types and sizing for conv_window_router.
// Holds default geometry, FSM/mode enums and beat counter widths.
package conv_router_pkg;

  localparam int DW_D   = 32;
  localparam int POY_D  = 3;
  localparam int POX_D  = 16;
  localparam int BUFW_D = 32;
  localparam int KMAX_D = 3;
  localparam int CW_D   = 12;

  localparam int HD   = KMAX_D - 1;
  localparam int GMAX = BUFW_D / POX_D;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;
  localparam int KXW  = 2;

  localparam logic [GW-1:0] G_LAST_S1 = GW'(GMAX - 1);
  localparam logic [GW-1:0] G_LAST_S2 = GW'(GMAX / 2 - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic {
    M_DW = 1'b0,
    M_PW = 1'b1
  } mode_e;

endpackage

// File: rtl/conv_window_router_mux.sv
// window_mux: picks one PE beat out of halo+current read data.
// Depthwise uses a right-aligned sliding window; pointwise is direct.
module window_mux
  import conv_router_pkg::*;
#(
  parameter int DW   = DW_D,
  parameter int POY  = POY_D,
  parameter int POX  = POX_D,
  parameter int BUFW = BUFW_D
) (
  input  logic [POY-1:0][BUFW-1:0][DW-1:0] cur,
  input  logic [POY-1:0][HD-1:0][DW-1:0]   halo,
  input  mode_e                            mode,
  input  logic [1:0]                       ntap,
  input  logic                             stride,
  input  logic [GW-1:0]                    g,
  input  logic [KXW-1:0]                   kx,
  output logic [POY-1:0][POX-1:0][DW-1:0]  pix
);

  localparam int CIW = $clog2(BUFW);
  localparam int HIW = (HD > 1) ? $clog2(HD) : 1;

  typedef logic [CIW-1:0] cidx_t;
  typedef logic [HIW-1:0] hidx_t;

  always_comb begin
    int s;
    int nt;
    int j;
    pix = '0;
    s   = stride ? 2 : 1;
    nt  = int'(ntap);
    j   = 0;
    for (int y = 0; y < POY; y++) begin
      for (int x = 0; x < POX; x++) begin
        if (mode == M_PW) begin
          pix[y][x] = cur[y][cidx_t'(int'(g) * POX + x)];
        end else begin
          // j indexes the window: ntap halo words then cur
          j = int'(g) * POX * s + x * s + int'(kx);
          if (j < nt) begin
            pix[y][x] = halo[y][hidx_t'(HD - nt + j)];
          end else if (j - nt < BUFW) begin
            pix[y][x] = cur[y][cidx_t'(j - nt)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_router.sv
// conv_window_router: line-buffer to PE-array pixel beat router.
// Define STALL_CNT_EN to add the saturating stall_cnt output port.
module conv_window_router
  import conv_router_pkg::*;
#(
  parameter int DW   = DW_D,
  parameter int POY  = POY_D,
  parameter int POX  = POX_D,
  parameter int BUFW = BUFW_D,
  parameter int KMAX = KMAX_D,
  parameter int CW   = CW_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    blk_start,
  input  logic                    cfg_pw,
  input  logic [1:0]              cfg_ksize,
  input  logic                    cfg_stride,
  input  logic [CW-1:0]           cfg_ncol,
  output logic                    buf_rd_en,
  output logic [CW-1:0]           buf_col,
  input  logic [POY*BUFW*DW-1:0]  buf_data,
  output logic                    pe_valid,
  input  logic                    pe_ready,
  output logic [POY*POX*DW-1:0]   pe_pixel,
  output logic [1:0]              pe_kx,
  output logic                    busy,
  output logic                    blk_done
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;

  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  ncol_q, ncol_d;
  logic [1:0]     ntap_q, ntap_d;
  logic           stride_q, stride_d;
  logic [GW-1:0]  g_q, g_d;
  logic [KXW-1:0] kx_q, kx_d;

  logic [POY-1:0][BUFW-1:0][DW-1:0] cur_q, cur_d;
  logic [POY-1:0][HD-1:0][DW-1:0]   halo_q, halo_d;

  logic rd_en_q, rd_en_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic done_q, done_d;

  logic [POY-1:0][POX-1:0][DW-1:0] pix;
  logic [GW-1:0]  glast;
  logic [KXW-1:0] klast;
  logic           fire;
  logic           last;

  assign glast = (mode_q == M_PW || !stride_q) ?
                 G_LAST_S1 : G_LAST_S2;
  assign klast = (mode_q == M_PW) ? '0 : ntap_q;
  assign fire  = valid_q && pe_ready;
  assign last  = (g_q == glast) && (kx_q == klast);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    col_d    = col_q;
    ncol_d   = ncol_q;
    ntap_d   = ntap_q;
    stride_d = stride_q;
    g_d      = g_q;
    kx_d     = kx_q;
    cur_d    = cur_q;
    halo_d   = halo_q;
    unique case (state_q)
      IDLE: begin
        if (blk_start) begin
          state_d  = REQ;
          mode_d   = cfg_pw ? M_PW : M_DW;
          ntap_d   = (cfg_ksize == 2'd3) ? 2'd2 : 2'd0;
          stride_d = cfg_stride;
          ncol_d   = cfg_ncol;
          col_d    = '0;
          g_d      = '0;
          kx_d     = '0;
          halo_d   = '0;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        state_d = EMIT;
        cur_d   = buf_data;
        g_d     = '0;
        kx_d    = '0;
      end
      EMIT: begin
        if (fire) begin
          if (last) begin
            g_d  = '0;
            kx_d = '0;
            for (int y = 0; y < POY; y++)
              for (int h = 0; h < HD; h++)
                halo_d[y][h] = cur_q[y][BUFW-HD+h];
            if (col_q == ncol_q - CW'(1)) begin
              state_d = DONE;
            end else begin
              state_d = REQ;
              col_d   = col_q + CW'(1);
            end
          end else if (kx_q == klast) begin
            kx_d = '0;
            g_d  = g_q + GW'(1);
          end else begin
            kx_d = kx_q + KXW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_en_d = (state_d == REQ);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == EMIT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= M_DW;
      col_q    <= '0;
      ncol_q   <= '0;
      ntap_q   <= '0;
      stride_q <= 1'b0;
      g_q      <= '0;
      kx_q     <= '0;
      cur_q    <= '0;
      halo_q   <= '0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      col_q    <= col_d;
      ncol_q   <= ncol_d;
      ntap_q   <= ntap_d;
      stride_q <= stride_d;
      g_q      <= g_d;
      kx_q     <= kx_d;
      cur_q    <= cur_d;
      halo_q   <= halo_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && blk_start)
      stall_d = '0;
    else if (valid_q && !pe_ready && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  window_mux #(
    .DW   (DW),
    .POY  (POY),
    .POX  (POX),
    .BUFW (BUFW)
  ) u_mux (
    .cur    (cur_q),
    .halo   (halo_q),
    .mode   (mode_q),
    .ntap   (ntap_q),
    .stride (stride_q),
    .g      (g_q),
    .kx     (kx_q),
    .pix    (pix)
  );

  assign buf_rd_en = rd_en_q;
  assign buf_col   = col_q;
  assign pe_valid  = valid_q;
  assign pe_pixel  = valid_q ? pix : '0;
  assign pe_kx     = valid_q ? kx_q : '0;
  assign busy      = busy_q;
  assign blk_done  = done_q;

endmodule

// File: tb/tb_conv_window_router.sv
// tb_conv_window_router: directed scoreboard bench for the router.
// Optional STALL_CNT_EN also checks the stall counter.
module tb_conv_window_router;

  localparam int DW   = 32;
  localparam int POY  = 3;
  localparam int POX  = 16;
  localparam int BUFW = 32;
  localparam int CW   = 12;
  localparam int PXW  = POY * POX * DW;

  typedef struct packed {
    logic [1:0]     kx;
    logic [PXW-1:0] pix;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic blk_start = 1'b0;
  logic cfg_pw = 1'b0;
  logic [1:0] cfg_ksize = 2'd1;
  logic cfg_stride = 1'b0;
  logic [CW-1:0] cfg_ncol = CW'(1);
  logic [POY*BUFW*DW-1:0] buf_data = '0;
  logic pe_ready = 1'b0;

  logic buf_rd_en;
  logic [CW-1:0] buf_col;
  logic pe_valid;
  logic [PXW-1:0] pe_pixel;
  logic [1:0] pe_kx;
  logic busy;
  logic blk_done;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int last_acc = -10;
  int blk = 0;
  int nblk = 0;
  beat_t sb[$];

  conv_window_router dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_start  (blk_start),
    .cfg_pw     (cfg_pw),
    .cfg_ksize  (cfg_ksize),
    .cfg_stride (cfg_stride),
    .cfg_ncol   (cfg_ncol),
    .buf_rd_en  (buf_rd_en),
    .buf_col    (buf_col),
    .buf_data   (buf_data),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .pe_pixel   (pe_pixel),
    .pe_kx      (pe_kx),
    .busy       (busy),
    .blk_done   (blk_done)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [DW-1:0] dat(int b, int c, int y, int i);
    return DW'(b * 100000 + c * 1000 + y * 100 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_beat(string tag, beat_t e);
    int bad;
    int bi;
    bad = -1;
    for (int i = 0; i < POY * POX; i++)
      if (bad < 0 && pe_pixel[i*DW +: DW] !== e.pix[i*DW +: DW])
        bad = i;
    bi = (bad < 0) ? 0 : bad;
    checks++;
    assert (pe_pixel === e.pix && pe_kx === e.kx) else begin
      failures++;
      $error("FAIL %s px=%0d obs=%0h exp=%0h kx obs=%0d exp=%0d",
             tag, bad, pe_pixel[bi*DW +: DW], e.pix[bi*DW +: DW],
             pe_kx, e.kx);
    end
  endtask

  // Reference model: builds every beat of a block from the data pattern.
  task automatic push_block(bit pw, int k, int s, int ncol);
    beat_t b;
    int gn, kn, w, idx;
    logic [DW-1:0] v;
    gn = pw ? BUFW / POX : BUFW / (POX * s);
    kn = pw ? 1 : k;
    for (int c = 0; c < ncol; c++)
      for (int g = 0; g < gn; g++)
        for (int kx = 0; kx < kn; kx++) begin
          b.pix = '0;
          b.kx  = 2'(kx);
          for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) begin
              if (pw) begin
                v = dat(blk, c, y, g * POX + x);
              end else begin
                w   = g * POX * s + x * s + kx;
                idx = w - (k - 1);
                if (idx >= 0)    v = dat(blk, c, y, idx);
                else if (c == 0) v = '0;
                else             v = dat(blk, c - 1, y, BUFW + idx);
              end
              b.pix[(y*POX+x)*DW +: DW] = v;
            end
          sb.push_back(b);
        end
  endtask

  task automatic start_block(bit pw, int k, int s, int ncol);
    nblk++;
    blk    = nblk;
    rd_cnt = 0;
    push_block(pw, k, s, ncol);
    cfg_pw     = pw;
    cfg_ksize  = 2'(k);
    cfg_stride = (s == 2);
    cfg_ncol   = CW'(ncol);
    blk_start  = 1'b1;
    tick();
    blk_start  = 1'b0;
    cfg_pw     = ~pw;
    cfg_ksize  = (k == 3) ? 2'd1 : 2'd3;
    cfg_stride = (s != 2);
    cfg_ncol   = CW'(ncol + 3);
    chk("req_rd_en", buf_rd_en, 1);
    chk("req_busy", busy, 1);
  endtask

  task automatic wait_done(string tag, int budget, bit rnd,
                           bit poke);
    int n;
    n = 0;
    while (!blk_done && n < budget) begin
      if (rnd) pe_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pe_ready = 1'b1;
    chk({tag, "_done_seen"}, blk_done, 1);
    if (blk_done) begin
      chk({tag, "_done_lat"}, cyc, last_acc + 1);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_busy_done"}, busy, 1);
      if (poke) blk_start = 1'b1;
      tick();
      blk_start = 1'b0;
      chk({tag, "_done_pulse"}, blk_done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      tick();
      chk({tag, "_no_restart"}, buf_rd_en, 0);
    end
  endtask

  // Line buffer: data valid exactly the cycle after buf_rd_en.
  initial begin
    int c;
    forever begin
      @(negedge clk);
      if (rst_n && buf_rd_en) begin
        c = int'(buf_col);
        @(posedge clk);
        #1;
        for (int y = 0; y < POY; y++)
          for (int i = 0; i < BUFW; i++)
            buf_data[(y*BUFW+i)*DW +: DW] = dat(blk, c, y, i);
        @(posedge clk);
        #1;
        for (int i = 0; i < POY * BUFW; i++)
          buf_data[i*DW +: DW] = $urandom;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (buf_rd_en) rd_cnt++;
    if (blk_done) done_cnt++;
    if (pe_valid) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL extra_beat obs=%0d exp=%0d", pe_kx, 0);
      end
      if (sb.size() > 0) begin
        if (pe_ready) begin
          cmp_beat("beat", sb[0]);
          void'(sb.pop_front());
          last_acc = cyc;
        end else begin
          cmp_beat("stall_hold", sb[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    tick();
    tick();
    chk("rst_valid", pe_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_done", blk_done, 0);
    chk("rst_kx", pe_kx, 0);
    chk("rst_col", buf_col, 0);
    chk("rst_pix_nz", 64'(|pe_pixel), 0);
`ifdef STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    rst_n = 1'b1;
    pe_ready = 1'b1;
    tick();

    // pointwise, two reads, latency check
    start_block(1'b1, 1, 1, 2);
    tick();
    chk("lat_wait", pe_valid, 0);
    tick();
    chk("lat_emit", pe_valid, 1);
    wait_done("pw2", 60, 1'b0, 1'b0);
    chk("pw2_reads", rd_cnt, 2);

    // depthwise K3 S1 single read
    start_block(1'b0, 3, 1, 1);
    wait_done("k3s1", 60, 1'b0, 1'b0);

    // depthwise K3 S2, halo carry, blk_start in DONE
    start_block(1'b0, 3, 2, 2);
    wait_done("k3s2", 60, 1'b0, 1'b1);
    chk("k3s2_reads", rd_cnt, 2);

    // fresh block sees zero halo
    start_block(1'b0, 3, 1, 1);
    wait_done("halo0", 60, 1'b0, 1'b0);

    // stall 5 cycles, blk_start while busy
    start_block(1'b0, 3, 1, 2);
    tick();
    tick();
    tick();
    pe_ready = 1'b0;
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    repeat (4) tick();
    chk("stall_valid", pe_valid, 1);
    pe_ready = 1'b1;
    wait_done("stall", 80, 1'b0, 1'b0);
    chk("stall_reads", rd_cnt, 2);
`ifdef STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 5);
`endif

    // random backpressure across modes
    start_block(1'b1, 1, 1, 3);
    wait_done("pw_rnd", 300, 1'b1, 1'b0);
    start_block(1'b0, 1, 2, 2);
    wait_done("k1s2_rnd", 300, 1'b1, 1'b0);
    start_block(1'b0, 1, 1, 2);
    wait_done("k1s1_rnd", 300, 1'b1, 1'b0);
    start_block(1'b0, 3, 1, 3);
    wait_done("k3s1_rnd", 300, 1'b1, 1'b0);

    // reset in EMIT aborts without blk_done
    start_block(1'b0, 3, 1, 2);
    tick();
    tick();
    pe_ready = 1'b0;
    tick();
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_valid", pe_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_kx", pe_kx, 0);
    chk("abort_pix_nz", 64'(|pe_pixel), 0);
    tick();
    rst_n = 1'b1;
    pe_ready = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, dc);
    chk("abort_idle", busy, 0);
    start_block(1'b0, 3, 1, 1);
    wait_done("post_rst", 60, 1'b0, 1'b0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
